rca_response_checker: RTL and testbench

- Synthesizable response checker on the output side of the 4-bit ripple-carry adder.
- Each valid cycle it samples the adder's operands (a, b, cin) and its results (s, cout), compares the results against a golden sum, and keeps vector and error counts.
- It latches the first failing vector and reports pass/fail once the exhaustive sweep of 2^(2*WIDTH+1) vectors is complete.
- It sits beside the adder in the exhaustive-sweep bench and in on-chip self-test wrappers.

---
 rtl/rca_response_checker.sv | 131 +++++++++++++
 tb/tb_rca_response_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_response_checker.sv
// Response checker for a WIDTH-bit ripple-carry adder: counts vectors/mismatches, latches first failure, reports pass after a sweep.
// mismatch is registered (1 cycle after the failing vector); optional hit bitmap under RCA_CHECKER_COVERAGE_EN gates pass.
module rca_response_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2*WIDTH+2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic [WIDTH-1:0]     s,
    input  logic                 cout,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [3*WIDTH+1:0]   first_fail,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
`ifdef RCA_CHECKER_COVERAGE_EN
    ,
    output logic                 cov_full
`endif
);

    localparam int VEC_BITS = 2*WIDTH+1;
    localparam int NUM_VEC  = 1 << VEC_BITS;
    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(NUM_VEC-1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH:0]   expected;
    logic [WIDTH:0]   got;
    logic             fail;
    logic             check;
    logic             have_fail;

    always_comb begin
        expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        got      = {cout, s};
        // Case inequality so that X/Z results in simulation are flagged as failures.
        fail     = (got !== expected);
        check    = (state == RUN) && valid && !start;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (stop || (check && vec_count >= LAST_C))
                        state_nx = DONE;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_count  <= '0;
            err_count  <= '0;
            first_fail <= '0;
            have_fail  <= 1'b0;
            mismatch   <= 1'b0;
        end else if (start) begin
            vec_count  <= '0;
            err_count  <= '0;
            first_fail <= '0;
            have_fail  <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            mismatch <= check && fail;
            if (check) begin
                if (vec_count != CNT_MAX)
                    vec_count <= vec_count + 1'b1;
                if (fail) begin
                    if (err_count != CNT_MAX)
                        err_count <= err_count + 1'b1;
                    if (!have_fail) begin
                        first_fail <= {a, b, cin, s, cout};
                        have_fail  <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef RCA_CHECKER_COVERAGE_EN
    logic [NUM_VEC-1:0] hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hit <= '0;
        else if (start)
            hit <= '0;
        else if (check)
            hit[{a, b, cin}] <= 1'b1;
    end

    always_comb begin
        cov_full = &hit;
        busy     = (state == RUN);
        done     = (state == DONE);
        pass     = done && (err_count == '0) && (vec_count == NUM_VEC_C) && cov_full;
    end
`else
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        pass = done && (err_count == '0) && (vec_count == NUM_VEC_C);
    end
`endif

endmodule

// File: tb/tb_rca_response_checker.sv
// Randomized scoreboard bench for rca_response_checker; reference model tracks counts and verdict arithmetically.
module tb_rca_response_checker;

    localparam int NV = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, valid = 1'b0, cin = 1'b0, cout = 1'b0;
    logic [3:0]  a = '0, b = '0, s = '0;
    logic        mismatch, busy, done, pass;
    logic [9:0]  vec_count, err_count;
    logic [13:0] first_fail;
`ifdef RCA_CHECKER_COVERAGE_EN
    logic        cov_full;
`endif

    rca_response_checker #(.WIDTH(4), .CNT_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .mismatch(mismatch), .vec_count(vec_count), .err_count(err_count),
        .first_fail(first_fail), .busy(busy), .done(done), .pass(pass)
`ifdef RCA_CHECKER_COVERAGE_EN
        , .cov_full(cov_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mm;
        int          vec;
        int          err;
        logic [13:0] ff;
        logic        busy;
        logic        done;
        logic        pass;
        logic        cov;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_run, m_done, m_have, m_mm;
    int          m_vec, m_err;
    logic [13:0] m_ff;
    bit          m_cov [NV];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit cov_all();
        for (int i = 0; i < NV; i++)
            if (!m_cov[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.mm   = m_mm;
        e.vec  = m_vec;
        e.err  = m_err;
        e.ff   = m_ff;
        e.busy = m_run;
        e.done = m_done;
        e.cov  = cov_all();
`ifdef RCA_CHECKER_COVERAGE_EN
        e.pass = m_done && m_err == 0 && m_vec == NV && e.cov;
`else
        e.pass = m_done && m_err == 0 && m_vec == NV;
`endif
        return e;
    endfunction

    task automatic model_clear();
        m_run = 0; m_done = 0; m_have = 0; m_mm = 0;
        m_vec = 0; m_err = 0; m_ff = '0;
        for (int i = 0; i < NV; i++) m_cov[i] = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit v, input logic [3:0] ia,
                              input logic [3:0] ib, input logic ic, input logic [3:0] is, input logic ico);
        logic [4:0] want;
        logic [4:0] have;
        m_mm = 0;
        if (st) begin
            model_clear();
            m_run = 1;
        end else if (m_run) begin
            if (v) begin
                want = 5'(int'(ia) + int'(ib) + int'(ic));
                have = {ico, is};
                m_vec = (m_vec < 1023) ? m_vec + 1 : 1023;
                m_cov[{ia, ib, ic}] = 1;
                if (have !== want) begin
                    m_mm = 1;
                    m_err = (m_err < 1023) ? m_err + 1 : 1023;
                    if (!m_have) begin
                        m_ff = {ia, ib, ic, is, ico};
                        m_have = 1;
                    end
                end
            end
            if (sp || (v && m_vec == NV)) begin
                m_run = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic cycle(input bit st, input bit sp, input bit v, input logic [3:0] ia,
                         input logic [3:0] ib, input logic ic, input logic [3:0] is, input logic ico);
        @(negedge clk);
        start = st; stop = sp; valid = v; a = ia; b = ib; cin = ic; s = is; cout = ico;
        model_step(st, sp, v, ia, ib, ic, is, ico);
        sb.push_back(snap());
    endtask

    // mode: 0 correct, 1 flip s[2] at C+3+1, 2 cout stuck 0, 3 rare random bit flip, 4 s unknown
    task automatic vec(input bit st, input bit sp, input bit v, input logic [8:0] idx, input int mode);
        logic [3:0] ia, ib, is;
        logic       ic, ico;
        ia = idx[8:5]; ib = idx[4:1]; ic = idx[0];
        {ico, is} = 5'(int'(ia) + int'(ib) + int'(ic));
        case (mode)
            1: if (ia == 4'hC && ib == 4'h3 && ic) is[2] = ~is[2];
            2: ico = 1'b0;
            3: if ($urandom_range(63) == 0) is = is ^ 4'(1 << $urandom_range(3));
            4: is = 4'bxxxx;
            default: ;
        endcase
        cycle(st, sp, v, ia, ib, ic, is, ico);
    endtask

    task automatic sweep(input int mode, input bit shuffle);
        int perm [NV];
        for (int i = 0; i < NV; i++) perm[i] = i;
        if (shuffle)
            for (int i = NV - 1; i > 0; i--) begin
                int j, t;
                j = $urandom_range(i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
        vec(1, 0, 1, 9'($urandom), 0);
        for (int i = 0; i < NV; i++) begin
            if ($urandom_range(3) == 0) vec(0, 0, 0, 9'($urandom), 0);
            vec(0, 0, 1, 9'(perm[i]), mode);
        end
        for (int i = 0; i < 3; i++) vec(0, 0, 1, 9'($urandom), 2);
    endtask

    task automatic settle();
        vec(0, 0, 0, 9'd0, 0);
        @(posedge clk);
        #2;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1; start = 0; stop = 0; valid = 0;
        model_clear();
        #1;
        chk("rst_mismatch", 32'(mismatch), 0);
        chk("rst_vec", 32'(vec_count), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_ff", 32'(first_fail), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        sb.push_back(snap());
        @(negedge clk);
        reset = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("mismatch", 32'(mismatch), 32'(e.mm));
            chk("vec_count", 32'(vec_count), 32'(e.vec));
            chk("err_count", 32'(err_count), 32'(e.err));
            chk("first_fail", 32'(first_fail), 32'(e.ff));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("pass", 32'(pass), 32'(e.pass));
`ifdef RCA_CHECKER_COVERAGE_EN
            chk("cov_full", 32'(cov_full), 32'(e.cov));
`endif
        end
    end

    initial begin
        model_clear();
        #2;
        chk("init_vec", 32'(vec_count), 0);
        chk("init_done", 32'(done), 0);
        chk("init_busy", 32'(busy), 0);
        rst_pulse();

        sweep(0, 0);
        settle();
        chk("sweep_pass", 32'(pass), 1);
        chk("sweep_vec", 32'(vec_count), NV);

        sweep(1, 0);
        settle();
        chk("fault_err", 32'(err_count), 1);
        // C+3+1 = 16 -> s=0, cout=1; s[2] flipped gives s=4
        chk("fault_ff", 32'(first_fail), 32'({4'hC, 4'h3, 1'b1, 4'h4, 1'b1}));
        chk("fault_pass", 32'(pass), 0);

        sweep(2, 1);
        settle();
        chk("carry_err", 32'(err_count), 256);
        chk("carry_pass", 32'(pass), 0);

        vec(1, 0, 0, 9'd0, 0);
        for (int i = 1; i <= 10; i++)
            vec(0, i == 10, 1, 9'($urandom), (i == 3) ? 4 : 0);
        for (int i = 0; i < 5; i++) vec(0, 0, 1, 9'($urandom), 2);
        settle();
        chk("stop_vec", 32'(vec_count), 10);
        chk("stop_done", 32'(done), 1);
        chk("stop_pass", 32'(pass), 0);

        vec(1, 0, 0, 9'd0, 0);
        for (int i = 0; i < 100; i++) vec(0, 0, 1, 9'(i), 3);
        rst_pulse();
        sweep(0, 1);
        settle();
        chk("rerun_pass", 32'(pass), 1);

        vec(1, 1, 1, 9'd5, 2);
        for (int i = 0; i < 4; i++) vec(0, 0, 1, 9'($urandom), 0);
        settle();
        chk("start_wins_busy", 32'(busy), 1);

        for (int i = 0; i < 400; i++)
            vec($urandom_range(49) == 0, $urandom_range(29) == 0, 1'($urandom_range(1)), 9'($urandom), 3);

`ifdef RCA_CHECKER_COVERAGE_EN
        vec(1, 0, 0, 9'd0, 0);
        for (int i = 0; i < NV; i++) vec(0, 0, 1, 9'd0, 0);
        settle();
        chk("cov_vec", 32'(vec_count), NV);
        chk("cov_full0", 32'(cov_full), 0);
        chk("cov_pass", 32'(pass), 0);
`endif

        settle();
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
